// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit
//   Register file (REGS x N, R0 hardwired to zero) with one write port for
//   writeback and a single read port that a small controller uses to fetch
//   two source operands (rs, then rt) on consecutive cycles for the ALU.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   start_i        : fetch request, sampled only in IDLE or DONE
//   rs_addr_i      : first source register, latched when start is accepted
//   rt_addr_i      : second source register, latched when start is accepted
//   wr_en_i        : writeback write enable
//   wr_addr_i      : writeback target (writes to R0 are dropped)
//   wr_data_i      : writeback data
//   busy_o         : high in READ_A and READ_B
//   done_o         : one-cycle pulse in DONE
//   op_a_o, op_b_o : registered operands, held until the next fetch overwrites them
//   state_o        : current controller state, for observation
//
// Handshake: start_i is a request sampled at a rising edge only while the
// controller is in IDLE or DONE; there is no ready signal, a start seen in
// READ_A/READ_B is dropped, not queued. done_o pulses for exactly one cycle
// and op_a_o/op_b_o are stable for that whole cycle.
module operand_fetch_unit #(
    parameter int N  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [N-1:0]  wr_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [N-1:0]  op_a_o,
    output logic [N-1:0]  op_b_o,
    output logic [1:0]    state_o
);

    localparam int REGS = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ra_q, ra_d;
    logic [AW-1:0]   rb_q, rb_d;
    logic [N-1:0]    op_a_q, op_a_d;
    logic [N-1:0]    op_b_q, op_b_d;
    logic [N-1:0]    mem_q [REGS];

    logic [AW-1:0]   rd_addr;
    logic [N-1:0]    rd_data;
    logic            wr_valid;

    assign wr_valid = wr_en_i && (wr_addr_i != '0);

    // Single read port: READ_B reads rt, every other state presents rs.
    // A write landing on the same edge as the capture is forwarded so the
    // operand never sees the stale array value.
    always_comb begin
        rd_addr = (state_q == READ_B) ? rb_q : ra_q;
        if (rd_addr == '0) begin
            rd_data = '0;
        end else if (wr_valid && (wr_addr_i == rd_addr)) begin
            rd_data = wr_data_i;
        end else begin
            rd_data = mem_q[rd_addr];
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = READ_A;
                    ra_d    = rs_addr_i;
                    rb_d    = rt_addr_i;
                end else begin
                    state_d = IDLE;
                end
            end
            READ_A: begin
                state_d = READ_B;
                op_a_d  = rd_data;
            end
            READ_B: begin
                state_d = DONE;
                op_b_d  = rd_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            for (int i = 0; i < REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            if (wr_valid) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    // Status outputs decode the registered state only.
    assign busy_o  = (state_q == READ_A) || (state_q == READ_B);
    assign done_o  = (state_q == DONE);
    assign op_a_o  = op_a_q;
    assign op_b_o  = op_b_q;
    assign state_o = state_q;

endmodule
